// File: rtl/head_sram_arb_if.sv
// Core-side bundle between head_sram_arb, its datapath clients and head_sram.
// Latency: none (pure wiring); read data returns one cycle after sram_ren.
// Backpressure: level requests held until rd_gnt / wr_gnt; no ready on return data.
interface head_sram_arb_if #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int BANK_NUM   = 16,
  parameter int BANK_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(BANK_NUM) + $clog2(BANK_DEPTH),
  parameter int LEN_WIDTH  = 3
);
  logic [REQ_NUM-1:0]            rd_req;
  logic [REQ_NUM*ADDR_WIDTH-1:0] rd_addr;
  logic [REQ_NUM*LEN_WIDTH-1:0]  rd_len;
  logic [REQ_NUM-1:0]            rd_gnt;
  logic [REQ_NUM-1:0]            rd_rvalid;
  logic                          rd_rlast;
  logic [DATA_WIDTH-1:0]         rd_rdata;
  logic [REQ_NUM-1:0]            wr_req;
  logic [REQ_NUM*ADDR_WIDTH-1:0] wr_addr;
  logic [REQ_NUM*DATA_WIDTH-1:0] wr_data;
  logic [REQ_NUM*2-1:0]          wr_byte_flag;
  logic [REQ_NUM-1:0]            wr_gnt;
  logic                          host_ren;
  logic                          host_wen;
  logic [ADDR_WIDTH-1:0]         sram_raddr;
  logic                          sram_ren;
  logic [ADDR_WIDTH-1:0]         sram_waddr;
  logic                          sram_wen;
  logic [DATA_WIDTH-1:0]         sram_wdata;
  logic [1:0]                    sram_byte_flag;
  logic [DATA_WIDTH-1:0]         sram_rdata;
  logic [15:0]                   perf_rd_stall;
  logic [15:0]                   perf_wr_stall;

  modport slave (
    input  rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_data, wr_byte_flag,
           host_ren, host_wen, sram_rdata,
    output rd_gnt, rd_rvalid, rd_rlast, rd_rdata, wr_gnt,
           sram_raddr, sram_ren, sram_waddr, sram_wen, sram_wdata, sram_byte_flag,
           perf_rd_stall, perf_wr_stall
  );

  modport master (
    output rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_data, wr_byte_flag,
           host_ren, host_wen, sram_rdata,
    input  rd_gnt, rd_rvalid, rd_rlast, rd_rdata, wr_gnt,
           sram_raddr, sram_ren, sram_waddr, sram_wen, sram_wdata, sram_byte_flag,
           perf_rd_stall, perf_wr_stall
  );
endinterface

// File: rtl/head_sram_arb.sv
// Round-robin arbiter + read-burst sequencer sharing head_sram core ports among REQ_NUM clients.
// Latency: write/read issue same cycle as grant; read data tag returns 1 cycle after sram_ren.
// Backpressure: core issue stalls a cycle after host_ren/host_wen; optional stall counters under HEAD_SRAM_ARB_PERF_EN.
module head_sram_arb #(
  parameter int REQ_NUM    = 4,
  parameter int DATA_WIDTH = 128,
  parameter int BANK_NUM   = 16,
  parameter int BANK_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(BANK_NUM) + $clog2(BANK_DEPTH),
  parameter int LEN_WIDTH  = 3
) (
  input logic            clk,
  input logic            rst,
  head_sram_arb_if.slave bus
);
  localparam int SEL_BITS   = $clog2(BANK_NUM);
  localparam int DEPTH_BITS = $clog2(BANK_DEPTH);
  localparam int PTR_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

  typedef enum logic {ST_IDLE, ST_BURST} rd_state_t;

  // First requester at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [PTR_W:0] rr_pick(input logic [REQ_NUM-1:0] req,
                                             input logic [PTR_W-1:0]   ptr);
    logic             found;
    logic [PTR_W-1:0] win;
    int               idx;
    found = 1'b0;
    win   = ptr;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = (int'(ptr) + i) % REQ_NUM;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    return {found, win};
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] id);
    if (int'(id) == REQ_NUM - 1) return '0;
    return id + PTR_W'(1);
  endfunction

  // Bank bits stay put; only the in-bank offset advances and wraps.
  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return {a[DEPTH_BITS +: SEL_BITS], a[DEPTH_BITS-1:0] + DEPTH_BITS'(1)};
  endfunction

  logic                  r_host_ren_q, r_host_wen_q;
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, r_rd_id;
  rd_state_t             r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_rd_cnt;
  logic                  r_rd_gap;
  logic                  r_tag_vld, r_tag_last;
  logic [PTR_W-1:0]      r_tag_id;

  logic                  w_wr_any, w_wr_issue, w_rd_any, w_rd_pend;
  logic [PTR_W-1:0]      w_wr_win, w_rd_win, w_beat_id;
  logic [REQ_NUM-1:0]    w_wr_gnt, w_rd_gnt, w_rvalid;
  logic                  w_ren, w_beat_last;
  logic [ADDR_WIDTH-1:0] w_raddr, w_win_addr;
  logic [LEN_WIDTH-1:0]  w_win_len;

  assign {w_wr_any, w_wr_win} = rr_pick(bus.wr_req, r_wr_ptr);
  assign {w_rd_any, w_rd_win} = rr_pick(bus.rd_req, r_rd_ptr);
  assign w_wr_issue = w_wr_any & ~r_host_wen_q & ~rst;
  assign w_win_addr = bus.rd_addr[w_rd_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_len  = bus.rd_len[w_rd_win*LEN_WIDTH +: LEN_WIDTH];

  // Host access lands in head_sram one cycle late, so stall on the delayed strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_host_ren_q <= 1'b0;
      r_host_wen_q <= 1'b0;
    end else begin
      r_host_ren_q <= bus.host_ren;
      r_host_wen_q <= bus.host_wen;
    end
  end

  // Write port: winner's slot drives the SRAM write port directly.
  always_comb begin
    w_wr_gnt           = '0;
    bus.sram_wen       = 1'b0;
    bus.sram_waddr     = '0;
    bus.sram_wdata     = '0;
    bus.sram_byte_flag = '0;
    if (w_wr_issue) begin
      w_wr_gnt[w_wr_win] = 1'b1;
      bus.sram_wen       = 1'b1;
      bus.sram_waddr     = bus.wr_addr[w_wr_win*ADDR_WIDTH +: ADDR_WIDTH];
      bus.sram_wdata     = bus.wr_data[w_wr_win*DATA_WIDTH +: DATA_WIDTH];
      bus.sram_byte_flag = bus.wr_byte_flag[w_wr_win*2 +: 2];
    end
  end

  // Write pointer moves past the winner only when a grant actually happens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_wr_ptr <= '0;
    else if (w_wr_issue) r_wr_ptr <= next_ptr(w_wr_win);
  end

  // Read FSM next-state and beat issue; IDLE waits out one gap cycle after a multi-beat burst.
  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    w_raddr     = '0;
    w_rd_gnt    = '0;
    w_beat_id   = r_rd_id;
    w_beat_last = 1'b0;
    w_rd_pend   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rd_pend = w_rd_any & ~r_rd_gap;
        if (w_rd_pend && !r_host_ren_q && !rst) begin
          w_ren              = 1'b1;
          w_raddr            = w_win_addr;
          w_rd_gnt[w_rd_win] = 1'b1;
          w_beat_id          = w_rd_win;
          w_beat_last        = (w_win_len == '0);
          if (w_win_len != '0) w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        w_rd_pend = 1'b1;
        if (!r_host_ren_q && !rst) begin
          w_ren       = 1'b1;
          w_raddr     = r_rd_addr;
          w_beat_last = (r_rd_cnt == LEN_WIDTH'(1));
          if (w_beat_last) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Burst context: owner, next address, beats still to issue, rotation pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_rd_id   <= '0;
      r_rd_addr <= '0;
      r_rd_cnt  <= '0;
      r_rd_gap  <= 1'b0;
    end else begin
      r_rd_gap <= w_ren & w_beat_last & (r_state == ST_BURST);
      if (w_ren) begin
        r_rd_addr <= addr_inc(w_raddr);
        if (r_state == ST_IDLE) begin
          r_rd_id  <= w_rd_win;
          r_rd_cnt <= w_win_len;
        end else begin
          r_rd_cnt <= r_rd_cnt - LEN_WIDTH'(1);
        end
        if (w_beat_last) r_rd_ptr <= next_ptr(w_beat_id);
      end
    end
  end

  // Return tag lines up with the registered SRAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= 1'b0;
      r_tag_id   <= '0;
      r_tag_last <= 1'b0;
    end else begin
      r_tag_vld  <= w_ren;
      r_tag_id   <= w_beat_id;
      r_tag_last <= w_ren & w_beat_last;
    end
  end

  // Decode the returning tag into the per-client valid.
  always_comb begin
    w_rvalid = '0;
    if (r_tag_vld) w_rvalid[r_tag_id] = 1'b1;
  end

  assign bus.sram_ren   = w_ren;
  assign bus.sram_raddr = w_raddr;
  assign bus.rd_gnt     = w_rd_gnt;
  assign bus.wr_gnt     = w_wr_gnt;
  assign bus.rd_rvalid  = w_rvalid;
  assign bus.rd_rlast   = r_tag_last;
  assign bus.rd_rdata   = bus.sram_rdata;

`ifdef HEAD_SRAM_ARB_PERF_EN
  logic [15:0] r_perf_rd, r_perf_wr;

  // Saturating counts of cycles where pending core work lost to the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_rd <= '0;
      r_perf_wr <= '0;
    end else begin
      if (r_host_ren_q && w_rd_pend && r_perf_rd != 16'hFFFF) r_perf_rd <= r_perf_rd + 16'd1;
      if (r_host_wen_q && w_wr_any  && r_perf_wr != 16'hFFFF) r_perf_wr <= r_perf_wr + 16'd1;
    end
  end

  assign bus.perf_rd_stall = r_perf_rd;
  assign bus.perf_wr_stall = r_perf_wr;
`else
  assign bus.perf_rd_stall = 16'h0000;
  assign bus.perf_wr_stall = 16'h0000;
`endif
endmodule
